// File: rtl/fell_stim_gen.sv
// Stimulus generator for a $fell-style checker: drives signal/enable patterns and
// produces the cycle-exact expected match/fail stream with saturating tallies.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; fields latched and tallies cleared on accept
// HIGH  | signal_out = 1 for the clamped high length
// LOW   | signal_out = 0 for the clamped low length, then next period
// DONE  | one-cycle done pulse, back to IDLE
module fell_stim_gen #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             en_always,
    output logic             signal_out,
    output logic             en_out,
    output logic             busy,
    output logic             done,
    output logic             exp_match,
    output logic             exp_fail,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] phase_cnt_nxt;
    logic [CNT_W-1:0] rep_left;
    logic [CNT_W-1:0] rep_left_nxt;
    logic [CNT_W-1:0] hi_len_q;
    logic [CNT_W-1:0] lo_len_q;
    logic [CNT_W-1:0] hi_clamp;
    logic [CNT_W-1:0] lo_clamp;
    logic             en_always_q;
    logic             phase_bit;
    logic             accept;
    logic             s1;
    logic             s2;
    logic             e1;
    logic             e2;

    assign hi_clamp = (high_len == '0) ? ONE : high_len;
    assign lo_clamp = (low_len == '0) ? ONE : low_len;

    assign busy       = (state == ST_HIGH) || (state == ST_LOW);
    assign signal_out = (state == ST_HIGH);
    assign done       = (state == ST_DONE);
    assign en_out     = busy & (en_always_q | phase_bit);

    // The checker sees a fall when the sample two cycles back was high and the last one low.
    assign exp_match = e2 & s2 & ~s1;
    assign exp_fail  = e2 & ~(s2 & ~s1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_cnt_nxt = phase_cnt;
        rep_left_nxt  = rep_left;
        accept        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept       = 1'b1;
                    rep_left_nxt = repeat_cnt;
                    if (repeat_cnt == '0) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt     = ST_HIGH;
                        phase_cnt_nxt = hi_clamp;
                    end
                end
            end
            ST_HIGH: begin
                if (phase_cnt == ONE) begin
                    state_nxt     = ST_LOW;
                    phase_cnt_nxt = lo_len_q;
                end else begin
                    phase_cnt_nxt = phase_cnt - ONE;
                end
            end
            ST_LOW: begin
                if (phase_cnt == ONE) begin
                    rep_left_nxt = rep_left - ONE;
                    if (rep_left == ONE) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt     = ST_HIGH;
                        phase_cnt_nxt = hi_len_q;
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt - ONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_cnt   <= '0;
            rep_left    <= '0;
            hi_len_q    <= ONE;
            lo_len_q    <= ONE;
            en_always_q <= 1'b0;
            phase_bit   <= 1'b0;
        end else begin
            phase_cnt <= phase_cnt_nxt;
            rep_left  <= rep_left_nxt;
            if (accept) begin
                hi_len_q    <= hi_clamp;
                lo_len_q    <= lo_clamp;
                en_always_q <= en_always;
                phase_bit   <= 1'b1;
            end else if (busy) begin
                phase_bit <= ~phase_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            e1 <= 1'b0;
            e2 <= 1'b0;
        end else begin
            s1 <= signal_out;
            s2 <= s1;
            e1 <= en_out;
            e2 <= e1;
        end
    end

    // Clearing on accept takes priority over a trailing expected bit from the previous run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else if (accept) begin
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            if (exp_match && (match_cnt != SAT)) begin
                match_cnt <= match_cnt + ONE;
            end
            if (exp_fail && (fail_cnt != SAT)) begin
                fail_cnt <= fail_cnt + ONE;
            end
        end
    end

endmodule

// File: doc/fell_stim_gen.md
# fell_stim_gen

Programmable stimulus generator that drives the `signal_in`/`en` inputs of a `$fell`-style sampled-value checker. It also produces the cycle-exact expected `match`/`fail` stream that checker must emit, plus saturating tallies of both. It sits beside the checker in checker-library benches and self-test wrappers, sharing `clk` and `rst_n`, so its expected outputs compare directly against the checker's outputs each cycle.

## Interface
- `CNT_W`, default 8: width of the length, repeat and tally fields.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request a run; accepted only in IDLE.
- `high_len`  in  CNT_W  cycles `signal_out` is high per period; latched on accept; 0 is treated as 1.
- `low_len`  in  CNT_W  cycles `signal_out` is low per period; latched on accept; 0 is treated as 1.
- `repeat_cnt`  in  CNT_W  number of high/low periods; latched on accept.
- `en_always`  in  1  latched on accept; 1 = `en_out` high on every busy cycle, 0 = `en_out` high on alternate busy cycles.
- `signal_out`  out  1  drives the checker's `signal_in`.
- `en_out`  out  1  drives the checker's `en`.
- `busy`  out  1  high while in HIGH or LOW state.
- `done`  out  1  one-cycle pulse at the end of a run.
- `exp_match`  out  1  expected checker `match` for the current cycle.
- `exp_fail`  out  1  expected checker `fail` for the current cycle.
- `match_cnt`  out  CNT_W  saturating count of `exp_match` cycles since the last accept.
- `fail_cnt`  out  CNT_W  saturating count of `exp_fail` cycles since the last accept.

## Operation
- **States:** IDLE, HIGH, LOW, DONE. All outputs are registered or decoded from registers.
- **Start accept:** `start` is accepted only in IDLE.
  - On accept, latch the fields (`high_len`, `low_len`, `repeat_cnt`, `en_always`) and clear both tallies.
  - If `repeat_cnt` = 0, go to DONE. Otherwise go to HIGH and load the phase counter with the clamped `high_len`.
  - `start` in any other state is ignored.
- **HIGH:** `signal_out` = 1. The phase counter decrements; on expiry, go to LOW and load the clamped `low_len`.
- **LOW:** `signal_out` = 0. On expiry, decrement the remaining repeat count.
  - If it reaches 0, go to DONE.
  - Otherwise go to HIGH and reload the clamped `high_len`.
- **DONE:** lasts one cycle with `done` = 1, then returns to IDLE. `signal_out` = 0 in IDLE and DONE.
- **en generation:** a phase bit is set to 1 on the first busy cycle and toggles every busy cycle.
  - `en_out` = `busy` & (latched `en_always` | phase bit).
  - `en_out` = 0 outside HIGH/LOW.
- **Expected model:** keep history registers s1 = `signal_out`(t-1), s2 = `signal_out`(t-2), and e2 = `en_out`(t-2).
  - `exp_match` = e2 & s2 & ~s1.
  - `exp_fail` = e2 & ~(s2 & ~s1).
  - The model runs in every state, including IDLE.
- **Tallies:** each tally increments on its respective expected bit and holds at 2^CNT_W−1.
- **Reset:** applies in any state; a reset mid-run aborts the run with no `done` pulse.
  - State returns to IDLE.
  - `signal_out`, `en_out`, `busy`, `done`, s1, s2, e2, `match_cnt` and `fail_cnt` all go to 0.
  - Hence `exp_match` = `exp_fail` = 0 out of reset.

## Timing
- `start` is sampled in cycle 0; the first HIGH cycle (`busy` = 1, `signal_out` = 1) is cycle 1.
- A run with R > 0 occupies cycles 1..R·(H+L), where H and L are the clamped lengths. `done` is asserted in cycle R·(H+L)+1. For R = 0, `done` is asserted in cycle 1.
- A new `start` is accepted in the cycle after DONE at the earliest.
- The expected outputs lag the stimulus by 2 cycles.
  - A falling edge whose first low cycle is f gives `exp_match` in cycle f+1.
  - That match requires `en_out` = 1 in cycle f−1, the last high cycle.
- The tallies are final and stable from cycle `done`+2 onward.
- Tally totals for a completed run:
  - `match_cnt` + `fail_cnt` = number of busy cycles with `en_out` = 1.
  - With `en_always` = 1 and no saturation, `match_cnt` = R.

## Test plan
- **Basic run:** H=2, L=3, R=2, `en_always`=1 → `signal_out` = 1100011000 over cycles 1–10; `busy` cycles 1–10; `done` in cycle 11; `exp_match` in cycles 4 and 9; final `match_cnt`=2, `fail_cnt`=8.
- **Alternate enable:** same run with `en_always`=0 → `en_out` high in cycles 1,3,5,7,9; `exp_match` only in cycle 9; final `match_cnt`=1, `fail_cnt`=4.
- **Zero repeat:** R=0 → `done` in cycle 1; `busy` and `signal_out` stay 0; tallies stay 0.
- **Length clamp:** H=0, L=0, R=3, `en_always`=1 → `signal_out` = 101010; `done` in cycle 7; `match_cnt`=3, `fail_cnt`=3.
- **Reset mid-run:** `rst_n` low in cycle 2 of the basic run → next cycle all outputs and tallies are 0 and state is IDLE; no `done` pulse; a subsequent `start` runs normally.
- **Start ignored / saturation:** `start` pulsed while busy is ignored. With CNT_W=2, H=1, L=1, R=5, `en_always`=1 → `match_cnt`=3 and `fail_cnt`=3, both saturated.
